// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_t;

  localparam int MEM_LATENCY_MAX = 8;
  localparam int CNT_W           = $clog2(MEM_LATENCY_MAX);

endpackage

// File: rtl/arb_latency_counter.sv
// Access-length counter: restarts at 0 on load, advances on count, and flags
// the last cycle of a MEM_LATENCY-cycle access.
module arb_latency_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(MEM_LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single fixed-latency memory port.
// Define MEM_PORT_ARB_FAIR_EN for round-robin conflict resolution; default is DM priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              port_req,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output arb_state_t        dbgState,
  output grant_t            dbgLastGrant
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_LATENCY_MAX) begin : gLatencyRange
    $error("mem_port_arbiter: MEM_LATENCY must be within 1..MEM_LATENCY_MAX");
  end

  // Handshake: a requester holds *_req (and its inputs) until its *_valid
  // pulse and changes them only on the following edge; *_valid lasts one cycle.
  arb_state_t        state, nextState;
  grant_t            lastGrant;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              weQ;
  logic [DATA_W-1:0] ifRdataQ, dmRdataQ;
  logic              busy, cntDone, cntLoad, cntCount;
  logic              latchIf, latchDm, pickDm;

  arb_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) uCounter (
    .clk   (clk),
    .clear (rst),
    .load  (cntLoad),
    .count (cntCount),
    .done  (cntDone)
  );

`ifdef MEM_PORT_ARB_FAIR_EN
  // On a conflict the requester that was not served last goes first.
  assign pickDm = dm_req & (~if_req | (lastGrant == GNT_IF));
`else
  assign pickDm = dm_req;
`endif

  assign busy     = (state != IDLE);
  assign if_valid = (state == BUSY_I) & cntDone;
  assign dm_valid = (state == BUSY_D) & cntDone;
  assign cntLoad  = latchIf | latchDm;
  assign cntCount = busy & ~cntDone;

  always_comb begin
    nextState = state;
    latchIf   = 1'b0;
    latchDm   = 1'b0;
    case (state)
      IDLE: begin
        if (pickDm) begin
          nextState = BUSY_D;
          latchDm   = 1'b1;
        end else if (if_req) begin
          nextState = BUSY_I;
          latchIf   = 1'b1;
        end
      end
      // On completion only the other requester may take the port next edge.
      BUSY_I: begin
        if (cntDone) begin
          if (dm_req) begin
            nextState = BUSY_D;
            latchDm   = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
      end
      BUSY_D: begin
        if (cntDone) begin
          if (if_req) begin
            nextState = BUSY_I;
            latchIf   = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= GNT_DM;
      addrQ     <= '0;
      wdataQ    <= '0;
      weQ       <= 1'b0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
    end else begin
      state <= nextState;
      if (latchIf) begin
        addrQ  <= if_addr;
        wdataQ <= '0;
        weQ    <= 1'b0;
      end else if (latchDm) begin
        addrQ  <= dm_addr;
        wdataQ <= dm_wdata;
        weQ    <= dm_we;
      end
      if (if_valid) begin
        lastGrant <= GNT_IF;
        ifRdataQ  <= port_rdata;
      end
      if (dm_valid) begin
        lastGrant <= GNT_DM;
        dmRdataQ  <= port_rdata;
      end
    end
  end

  // Port is driven only while an access is in flight so it reads as all-zero when idle.
  assign port_req   = busy;
  assign port_we    = busy & weQ;
  assign port_addr  = busy ? addrQ : '0;
  assign port_wdata = busy ? wdataQ : '0;

  assign if_rdata  = if_valid ? port_rdata : ifRdataQ;
  assign dm_rdata  = dm_valid ? port_rdata : dmRdataQ;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  assign dbgState     = state;
  assign dbgLastGrant = lastGrant;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified instruction/data memory between two requesters: the fetch stage (IF port) and the memory stage (DM port, loads and stores).
- Sequences each access over MEM_LATENCY cycles and returns read data with a one-cycle valid pulse.
- Produces stall_if and stall_mem for the hazard logic, so the pipeline freezes while a stage waits for the shared port.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LATENCY, 2, cycles the memory port is held per access; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; meaningful only when if_valid=1.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held until dm_valid.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; meaningful only when dm_valid=1.
- dm_valid  out  1  one-cycle completion pulse; also pulses for stores (acknowledge).
- port_req  out  1  memory access active.
- port_we  out  1  memory write enable.
- port_addr  out  ADDR_W  memory address.
- port_wdata  out  DATA_W  memory write data.
- port_rdata  in  DATA_W  memory read data; valid on the last cycle of an access.
- stall_if  out  1  if_req & ~if_valid (combinational).
- stall_mem  out  1  dm_req & ~dm_valid (combinational).

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. A cnt register counts 0..MEM_LATENCY-1.
- Reset (synchronous, also mid-access): state=IDLE, cnt=0, last_grant=DM. The abort is silent: no valid pulse.
- Output values during and after reset:
  - port_req=0, port_we=0, port_addr=0, port_wdata=0.
  - if_valid=0, dm_valid=0.
  - if_rdata=0, dm_rdata=0 (registered copies).
- IDLE arbitration:
  - Only dm_req pending -> BUSY_D.
  - Only if_req pending -> BUSY_I.
  - Both pending -> priority rule (see Optional Feature). Default is DM wins.
  - Neither pending -> stay in IDLE.
  - The grant is registered: if a request is seen in cycle t, port_req=1 in cycles t+1..t+MEM_LATENCY.
- BUSY_x: the port outputs are driven from the granted requester's inputs and latched at grant time. They are held stable for the whole access even if the requester changes its inputs. port_we=dm_we for DM, 0 for IF.
- Completion cycle (cnt==MEM_LATENCY-1):
  - The matching *_valid is 1 combinationally in that cycle.
  - *_rdata is the combinational pass-through of port_rdata in that cycle and holds the registered copy afterwards.
  - last_grant is updated to the served requester.
- Back-to-back accesses: on the completion cycle the arbiter re-arbitrates with the just-served requester excluded. If the other requester is pending, the next edge enters the other BUSY state directly, with no IDLE bubble. Otherwise it goes to IDLE.
- The requester drops or changes its request on the edge after valid. A same-requester re-request therefore needs one IDLE cycle: throughput is at most 1 access per MEM_LATENCY+1 cycles per requester.
- Protocol violation (req deasserted before valid): the access still completes and valid still pulses. Verification flags it with an assertion; the RTL does not.
- stall_if and stall_mem are never 1 while the corresponding req=0.
- if_valid and dm_valid are never 1 in the same cycle.

Optional Feature:
- Macro: MEM_PORT_ARB_FAIR_EN.
- Defined: on simultaneous if_req and dm_req in IDLE, the requester not equal to last_grant wins (round-robin). This bounds the fetch wait to one data access.
- Undefined: the DM port always wins on conflict (strict priority; the older instruction makes progress). last_grant is still maintained but ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}.
  - grant_t enum {GNT_IF, GNT_DM}.
  - localparam MEM_LATENCY_MAX=8, used by the parameter-range check and the cnt width ($clog2).
- One sub-module, arb_latency_counter: load, count, and a done flag at MEM_LATENCY-1, with synchronous clear. The FSM, latching and output muxing stay in mem_port_arbiter.

Test Plan:
- Single fetch: MEM_LATENCY=2, if_req=1 with if_addr=0x0000_0010 at cycle 0.
  - port_req=1 in cycles 1-2 with port_addr=0x10.
  - if_valid=1 in cycle 2, with if_rdata=port_rdata=0x0051_0093.
  - stall_if=1 in cycles 0-1.
- Store acknowledge: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF.
  - port_we=1 and port_wdata=0xDEADBEEF for MEM_LATENCY cycles.
  - dm_valid pulses once; dm_rdata is ignored.
- Conflict, strict priority (macro undefined): if_req and dm_req both asserted at cycle 0, MEM_LATENCY=2.
  - DM served in cycles 1-2, dm_valid in cycle 2.
  - IF served in cycles 3-4 with no bubble, if_valid in cycle 4.
  - stall_if=1 in cycles 0-3.
- Fairness (macro defined): last_grant=DM, then both requests asserted.
  - IF granted first.
  - Repeat the conflict immediately: DM is granted next.
- Reset mid-access: assert rst in cycle 1 of a load with MEM_LATENCY=4.
  - Next cycle: port_req=0, dm_valid never pulses, state=IDLE.
  - A fresh dm_req after reset completes normally.
- Latency sweep: MEM_LATENCY=1 and 8, random back-to-back IF/DM traffic.
  - Every request receives exactly one valid pulse.
  - Port signals stay stable within each access.
  - if_valid and dm_valid are never both 1 in the same cycle.
